// File: rtl/i2c_target.sv
// I2C target: fixed 7-bit address, 8-bit auto-incrementing register pointer, one-clk byte strobes to a local register port.
// Latency: bus events act 3 clk after the pad edge (clk >= 16x SCL); no backpressure, the local port must take a strobe every clk.
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h49
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        PTR,
        WDATA,
        READ,
        IDLE_WAIT
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       scl_m;
    logic       scl_s;
    logic       scl_h;
    logic       sda_m;
    logic       sda_s;
    logic       sda_h;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;
    logic [3:0] bit_cnt;
    logic [3:0] bit_cnt_nxt;
    logic [7:0] shreg;
    logic [7:0] shreg_nxt;
    logic [7:0] tx;
    logic [7:0] tx_nxt;
    logic [7:0] ptr;
    logic [7:0] ptr_nxt;
    logic [7:0] reg_addr_nxt;
    logic [7:0] reg_wdata_nxt;
    logic [7:0] byte_in;
    logic       sda_oe_nxt;
    logic       busy_nxt;
    logic       reg_wr_nxt;
    logic       reg_rd_nxt;
    logic       rd_dly;

    // Synchronisers reset to the idle-bus level so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m <= 1'b1;
            scl_s <= 1'b1;
            scl_h <= 1'b1;
            sda_m <= 1'b1;
            sda_s <= 1'b1;
            sda_h <= 1'b1;
        end else begin
            scl_m <= scl;
            scl_s <= scl_m;
            scl_h <= scl_s;
            sda_m <= sda_in;
            sda_s <= sda_m;
            sda_h <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;
    assign byte_in   = {shreg[6:0], sda_s};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            shreg     <= 8'h00;
            tx        <= 8'h00;
            ptr       <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            rd_dly    <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shreg     <= shreg_nxt;
            tx        <= tx_nxt;
            ptr       <= ptr_nxt;
            reg_addr  <= reg_addr_nxt;
            reg_wdata <= reg_wdata_nxt;
            sda_oe    <= sda_oe_nxt;
            busy      <= busy_nxt;
            reg_wr    <= reg_wr_nxt;
            reg_rd    <= reg_rd_nxt;
            rd_dly    <= reg_rd;
        end
    end

    // bit_cnt: 0..7 bits seen, 8 = byte done / ACK pending, 9 = inside the ACK slot.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shreg_nxt     = shreg;
        tx_nxt        = rd_dly ? reg_rdata : tx;
        ptr_nxt       = ptr;
        reg_addr_nxt  = reg_addr;
        reg_wdata_nxt = reg_wdata;
        sda_oe_nxt    = sda_oe;
        busy_nxt      = busy;
        reg_wr_nxt    = 1'b0;
        reg_rd_nxt    = 1'b0;
        if (stop_det) begin
            state_nxt   = IDLE;
            bit_cnt_nxt = 4'd0;
            sda_oe_nxt  = 1'b0;
            busy_nxt    = 1'b0;
        end else if (start_det) begin
            state_nxt   = ADDR;
            bit_cnt_nxt = 4'd0;
            shreg_nxt   = 8'h00;
            sda_oe_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE, IDLE_WAIT: begin
                    sda_oe_nxt = 1'b0;
                end
                ADDR, PTR, WDATA: begin
                    if (scl_rise && bit_cnt < 4'd8) begin
                        shreg_nxt   = byte_in;
                        bit_cnt_nxt = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == ADDR) begin
                                if (byte_in[7:1] == TARGET_ADDR) begin
                                    busy_nxt = 1'b1;
                                end else begin
                                    state_nxt   = IDLE;
                                    bit_cnt_nxt = 4'd0;
                                end
                            end else if (state == PTR) begin
                                ptr_nxt = byte_in;
                            end else begin
                                reg_wr_nxt    = 1'b1;
                                reg_addr_nxt  = ptr;
                                reg_wdata_nxt = byte_in;
                                ptr_nxt       = ptr + 8'd1;
                            end
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_nxt  = 1'b1;
                        bit_cnt_nxt = 4'd9;
                        // Fetch the first read byte while the ACK slot runs.
                        if (state == ADDR && shreg[0]) begin
                            reg_rd_nxt   = 1'b1;
                            reg_addr_nxt = ptr;
                        end
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        sda_oe_nxt  = 1'b0;
                        bit_cnt_nxt = 4'd0;
                        if (state == ADDR) begin
                            if (shreg[0]) begin
                                state_nxt  = READ;
                                sda_oe_nxt = ~tx[7];
                                tx_nxt     = {tx[6:0], 1'b0};
                            end else begin
                                state_nxt = PTR;
                            end
                        end else begin
                            state_nxt = WDATA;
                        end
                    end
                end
                READ: begin
                    if (scl_rise) begin
                        if (bit_cnt < 4'd8) begin
                            bit_cnt_nxt = bit_cnt + 4'd1;
                        end else if (bit_cnt == 4'd8) begin
                            if (!sda_s) begin
                                ptr_nxt      = ptr + 8'd1;
                                reg_rd_nxt   = 1'b1;
                                reg_addr_nxt = ptr + 8'd1;
                                bit_cnt_nxt  = 4'd9;
                            end else begin
                                state_nxt   = IDLE_WAIT;
                                sda_oe_nxt  = 1'b0;
                                bit_cnt_nxt = 4'd0;
                            end
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_nxt = 1'b0;
                        end else if (bit_cnt != 4'd0) begin
                            sda_oe_nxt = ~tx[7];
                            tx_nxt     = {tx[6:0], 1'b0};
                            if (bit_cnt == 4'd9) begin
                                bit_cnt_nxt = 4'd0;
                            end
                        end
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    sda_oe_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller model at SCL = clk/32 plus a scoreboard for the register strobes.
`timescale 1ns/1ps
module tb_i2c_target;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       ctrl_low = 1'b0;
    logic       sda_line;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    logic [7:0]  mem [256];
    logic [15:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [15:0] e_wr;
    logic [7:0]  e_rd;
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;
    int          tests = 0;
    int          fails = 0;

    assign sda_line = ~(ctrl_low | sda_oe);

    i2c_target #(.TARGET_ADDR(7'h49)) dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl),
        .sda_in    (sda_line),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered register-file model: data follows reg_rd by one clk.
    always @(posedge clk) begin
        if (reg_rd) reg_rdata <= mem[reg_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sda_oe) oe_seen = 1'b1;
        if (busy) busy_seen = 1'b1;
        if (reg_wr) begin
            if (exp_wr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_reg_wr: addr 0x%0h data 0x%0h, expected none", reg_addr, reg_wdata);
            end else begin
                e_wr = exp_wr_q.pop_front();
                check("reg_wr_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, e_wr});
            end
        end
        if (reg_rd) begin
            if (exp_rd_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_reg_rd: addr 0x%0h, expected none", reg_addr);
            end else begin
                e_rd = exp_rd_q.pop_front();
                check("reg_rd_addr", {24'd0, reg_addr}, {24'd0, e_rd});
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_start();
        ctrl_low = 1'b1;
        wait_clk(16);
        scl = 1'b0;
        wait_clk(8);
    endtask

    task automatic bus_rstart();
        ctrl_low = 1'b0;
        wait_clk(8);
        scl = 1'b1;
        wait_clk(16);
        ctrl_low = 1'b1;
        wait_clk(16);
        scl = 1'b0;
        wait_clk(8);
    endtask

    task automatic bus_stop();
        ctrl_low = 1'b1;
        wait_clk(8);
        scl = 1'b1;
        wait_clk(16);
        ctrl_low = 1'b0;
        wait_clk(16);
    endtask

    task automatic bit_wr(input logic b);
        ctrl_low = ~b;
        wait_clk(8);
        scl = 1'b1;
        wait_clk(16);
        scl = 1'b0;
        wait_clk(8);
    endtask

    task automatic bit_rd(output logic b, output logic oe);
        ctrl_low = 1'b0;
        wait_clk(8);
        scl = 1'b1;
        wait_clk(8);
        b  = sda_line;
        oe = sda_oe;
        wait_clk(8);
        scl = 1'b0;
        wait_clk(8);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic b;
        logic oe;
        for (int i = 7; i >= 0; i--) bit_wr(d[i]);
        bit_rd(b, oe);
        check({name, "_ack_oe"}, {31'd0, oe}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic ack, input string name);
        logic [7:0] d;
        logic b;
        logic oe;
        for (int i = 7; i >= 0; i--) begin
            bit_rd(b, oe);
            d[i] = b;
        end
        check(name, {24'd0, d}, {24'd0, exp});
        bit_wr(~ack);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h96] = 8'h5A;
        mem[8'h97] = 8'h3C;
        mem[8'h10] = 8'h21;
        mem[8'h00] = 8'hC3;

        // Reset state.
        wait_clk(5);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_strobes", {30'd0, reg_wr, reg_rd}, 32'd0);
        check("rst_addr_wdata", {16'd0, reg_addr, reg_wdata}, 32'd0);
        rst = 1'b0;
        wait_clk(10);

        // Write: pointer 0x96, data 0xAA, 0xCC.
        bus_start();
        write_byte(8'h92, 1'b1, "w_addr");
        check("w_busy_after_addr", {31'd0, busy}, 32'd1);
        write_byte(8'h96, 1'b1, "w_ptr");
        exp_wr_q.push_back(16'h96AA);
        write_byte(8'hAA, 1'b1, "w_d0");
        exp_wr_q.push_back(16'h97CC);
        write_byte(8'hCC, 1'b1, "w_d1");
        check("w_busy_before_stop", {31'd0, busy}, 32'd1);
        bus_stop();
        check("w_busy_after_stop", {31'd0, busy}, 32'd0);
        check("w_wr_q_empty", exp_wr_q.size(), 32'd0);

        // Read via pointer write, repeated START, then 0x93.
        bus_start();
        write_byte(8'h92, 1'b1, "r_addr_w");
        write_byte(8'h96, 1'b1, "r_ptr");
        bus_rstart();
        check("r_busy_after_sr", {31'd0, busy}, 32'd1);
        exp_rd_q.push_back(8'h96);
        write_byte(8'h93, 1'b1, "r_addr_r");
        exp_rd_q.push_back(8'h97);
        read_byte(8'h5A, 1'b1, "r_byte0");
        read_byte(8'h3C, 1'b0, "r_byte1");
        wait_clk(4);
        check("r_released_after_nack", {31'd0, sda_oe}, 32'd0);
        bus_stop();
        check("r_busy_after_stop", {31'd0, busy}, 32'd0);
        check("r_rd_q_empty", exp_rd_q.size(), 32'd0);

        // Address mismatch.
        oe_seen   = 1'b0;
        busy_seen = 1'b0;
        bus_start();
        write_byte(8'hA0, 1'b0, "mm_addr");
        write_byte(8'h11, 1'b0, "mm_data");
        bus_stop();
        check("mm_oe_never", {31'd0, oe_seen}, 32'd0);
        check("mm_busy_never", {31'd0, busy_seen}, 32'd0);

        // Pointer wrap.
        bus_start();
        write_byte(8'h92, 1'b1, "wrap_addr");
        write_byte(8'hFF, 1'b1, "wrap_ptr");
        exp_wr_q.push_back(16'hFF01);
        write_byte(8'h01, 1'b1, "wrap_d0");
        exp_wr_q.push_back(16'h0002);
        write_byte(8'h02, 1'b1, "wrap_d1");
        bus_stop();
        check("wrap_wr_q_empty", exp_wr_q.size(), 32'd0);

        // STOP after 4 data bits, then a normal write must still work.
        bus_start();
        write_byte(8'h92, 1'b1, "ab_addr");
        write_byte(8'h20, 1'b1, "ab_ptr");
        bit_wr(1'b1);
        bit_wr(1'b0);
        bit_wr(1'b1);
        bit_wr(1'b0);
        bus_stop();
        check("ab_busy_after_stop", {31'd0, busy}, 32'd0);
        bus_start();
        write_byte(8'h92, 1'b1, "ab2_addr");
        write_byte(8'h30, 1'b1, "ab2_ptr");
        exp_wr_q.push_back(16'h3055);
        write_byte(8'h55, 1'b1, "ab2_d0");
        bus_stop();
        check("ab_wr_q_empty", exp_wr_q.size(), 32'd0);

        // Reset during a read data bit (first bit of 0x21 is 0, so sda is driven).
        bus_start();
        write_byte(8'h92, 1'b1, "rr_addr_w");
        write_byte(8'h10, 1'b1, "rr_ptr");
        bus_rstart();
        exp_rd_q.push_back(8'h10);
        write_byte(8'h93, 1'b1, "rr_addr_r");
        ctrl_low = 1'b0;
        wait_clk(8);
        scl = 1'b1;
        wait_clk(8);
        check("rr_driving_before_rst", {31'd0, sda_oe}, 32'd1);
        rst = 1'b1;
        wait_clk(1);
        check("rr_sda_oe_after_rst", {31'd0, sda_oe}, 32'd0);
        check("rr_busy_after_rst", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        wait_clk(7);
        scl = 1'b0;
        wait_clk(8);
        bus_stop();
        // Pointer must be back at 0x00.
        bus_start();
        exp_rd_q.push_back(8'h00);
        write_byte(8'h93, 1'b1, "rr2_addr_r");
        read_byte(8'hC3, 1'b0, "rr2_byte0");
        bus_stop();
        check("rr_rd_q_empty", exp_rd_q.size(), 32'd0);
        check("final_wr_q_empty", exp_wr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) that answers the team's i2c_controller on the same two-wire bus.
- Recognises a fixed 7-bit address and keeps an 8-bit register pointer.
- Converts bus write/read transfers into single-cycle byte strobes on a simple local register interface.
- Oversampled design: scl and sda are sampled on the system clock, which must be at least 16x the SCL rate.

Parameters:
- TARGET_ADDR, 7'h49: 7-bit bus address this target acknowledges.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- scl  input  1  bus clock (asynchronous to clk)
- sda_in  input  1  bus data as read from the pad
- sda_oe  output  1  1 = pull sda low; 0 = release (open-drain)
- reg_addr  output  8  register pointer presented with reg_wr and reg_rd
- reg_wdata  output  8  write byte, valid while reg_wr=1
- reg_wr  output  1  one-clk write strobe
- reg_rd  output  1  one-clk read request
- reg_rdata  input  8  read byte, sampled exactly 1 clk after reg_rd
- busy  output  1  high from a START with address match until STOP

Behaviour:
- Reset (synchronous, active-high):
  - All outputs 0.
  - State IDLE; pointer 0x00; shift register and bit counter cleared.
  - Reset asserted mid-transfer releases sda on the next clk and emits no strobe.
- Input synchronisation and edge detection:
  - scl and sda_in each pass through a 2-FF synchroniser plus one history FF.
  - Edge and condition detection uses the synchronised signals only.
  - START = sda falls while scl high. STOP = sda rises while scl high.
  - Data is sampled on the scl rising edge.
  - sda_oe changes only on an scl falling edge, or when returning to release.
- State machine:
  - IDLE:
    - START -> ADDR; otherwise ignore the bus.
  - ADDR:
    - Shift 8 bits MSB first.
    - If bits[7:1] == TARGET_ADDR: ACK, busy=1, go to PTR if bit0=0, READ if bit0=1.
    - On mismatch: no ACK -> IDLE, waiting for the next START.
  - ACK slot:
    - Drive sda_oe=1 from the falling edge after bit 8 until the next falling edge.
  - PTR:
    - The first byte after addr+W loads the pointer, then ACK -> WDATA.
  - WDATA:
    - On the 8th rising edge: reg_wr=1 for one clk, with reg_addr = pointer and reg_wdata = the byte.
    - Then ACK; pointer increments 0xFF -> 0x00 (wrap); stay in WDATA.
  - READ:
    - On entry (at the address-ACK falling edge), pulse reg_rd with reg_addr = pointer.
    - Latch reg_rdata on the next clk.
    - Drive bits MSB first: sda_oe = ~bit, updated on each scl falling edge, starting at the falling edge that ends the ACK slot.
    - After bit 8, release sda and sample the controller's ACK on the 9th rising edge.
    - ACK (0): pointer++, then reg_rd/latch before the next falling edge, and continue.
    - NACK (1): release sda -> IDLE_WAIT.
  - IDLE_WAIT:
    - Release the bus; wait for STOP or START.
- STOP, from any state:
  - -> IDLE, busy=0, sda released.
  - A partial byte is discarded (no reg_wr).
- Repeated START, from any state:
  - -> ADDR, bit counter cleared, pointer retained.
  - busy stays high until STOP.
- The pointer persists across transactions, so pointer-write, Sr, read works.
- Minimum latency from bus event to internal action is 3 clk (synchroniser + edge detect), which is why clk >= 16x SCL is required.
- A START and a STOP never occur on the same sampled edge; if both flags are seen in the same clk, STOP takes priority.

Test Plan:
- Write: START, 0x92, 0x96, 0xAA, 0xCC, STOP (bus model with SCL = clk/32) -> required response:
  - ACK (sda_oe=1) in all 4 ACK slots.
  - reg_wr pulses twice: (reg_addr=0x96, reg_wdata=0xAA), then (0x97, 0xCC).
  - busy=1 from START to STOP, then 0.
- Read: START, 0x92, 0x96, Sr, 0x93; reg_rdata returns 0x5A then 0x3C; controller ACKs the first byte and NACKs the second -> required response:
  - sda carries 0x5A then 0x3C.
  - reg_rd pulses with reg_addr=0x96, then 0x97.
  - sda is released after the NACK.
- Address mismatch: START, 0xA0, 0x11, STOP -> sda_oe stays 0 for the whole transfer; no reg_wr/reg_rd; busy stays 0.
- Wrap: write pointer 0xFF, then data 0x01, 0x02 -> reg_wr at 0xFF, then 0x00.
- Aborts:
  - STOP after 4 data bits of a write byte -> no reg_wr; state returns to IDLE.
  - rst asserted during a read data bit -> sda_oe=0 and busy=0 on the next clk; pointer=0x00.
